// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box, linear transforms, FK constants and the
// data-path engine state encoding.
package sm4_pkg;

    localparam int unsigned NumRounds = 32;

    localparam logic [31:0] Fk0 = 32'ha3b1bac6;
    localparam logic [31:0] Fk1 = 32'h56aa3350;
    localparam logic [31:0] Fk2 = 32'h677d9197;
    localparam logic [31:0] Fk3 = 32'hb27022dc;

    typedef enum logic [1:0] {StIdle, StPref, StRun, StDone} sm4_state_e;

    // Entry 0 occupies the top byte.
    localparam logic [2047:0] SboxTable = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sm4_sbox(input logic [7:0] b);
        return SboxTable[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [31:0] sm4_rol(input logic [31:0] b, input int unsigned n);
        return (b << n) | (b >> (32 - n));
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ sm4_rol(b, 2) ^ sm4_rol(b, 10) ^ sm4_rol(b, 18) ^ sm4_rol(b, 24);
    endfunction

endpackage

// File: rtl/sm4_round.sv
// One combinational SM4 round: x_new = x0 ^ L(tau(x1 ^ x2 ^ x3 ^ rk)).
module sm4_round (
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] rk,
    output logic [31:0] x_new
);
    import sm4_pkg::*;

    logic [31:0] b;
    logic [31:0] tau;

    assign b = x1 ^ x2 ^ x3 ^ rk;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign tau[8*i +: 8] = sm4_sbox(b[8*i +: 8]);
    end

    assign x_new = x0 ^ sm4_l(tau);

endmodule

// File: rtl/sm4_crypt_core.sv
// Iterative SM4 encrypt/decrypt engine: one round per clock, round keys read
// from the key-expansion RAM one cycle ahead of use.
module sm4_crypt_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_loaded,
    input  logic         decrypt,
    input  logic [127:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [4:0]   ikey_cnt,
    input  logic [31:0]  ikey,
    output logic [127:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy
);
    import sm4_pkg::*;

    localparam logic [4:0] LastRound = 5'(NumRounds - 1);

    sm4_state_e   state_q, state_d;
    logic [4:0]   r_q, r_d;
    logic [127:0] x_q, x_d;
    logic [127:0] dout_q, dout_d;
    logic         dec_q, dec_d;
    logic [31:0]  x_new;

    sm4_round u_round (
        .x0    (x_q[127:96]),
        .x1    (x_q[95:64]),
        .x2    (x_q[63:32]),
        .x3    (x_q[31:0]),
        .rk    (ikey),
        .x_new (x_new)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            x_q     <= '0;
            dout_q  <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            dout_q  <= dout_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        dout_d  = dout_q;
        dec_d   = dec_q;
        case (state_q)
            StIdle: begin
                if (din_valid && key_loaded) begin
                    state_d = StPref;
                    x_d     = din;
                    dec_d   = decrypt;
                    r_d     = '0;
                end
            end
            StPref: begin
                state_d = key_loaded ? StRun : StIdle;
            end
            StRun: begin
                if (!key_loaded) begin
                    state_d = StIdle;
                end else begin
                    x_d = {x_q[95:0], x_new};
                    r_d = r_q + 5'd1;
                    if (r_q == LastRound) begin
                        state_d = StDone;
                        // Reverse transform R over the final four words.
                        dout_d  = {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
                    end
                end
            end
            StDone: begin
                if (dout_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address is for the round executed in the following cycle.
    always_comb begin
        ikey_cnt = '0;
        case (state_q)
            StPref: ikey_cnt = dec_q ? LastRound : 5'd0;
            StRun: begin
                if (r_q != LastRound) ikey_cnt = dec_q ? (5'd30 - r_q) : (r_q + 5'd1);
            end
            default: ikey_cnt = '0;
        endcase
    end

    assign din_ready  = (state_q == StIdle) && key_loaded;
    assign dout_valid = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign dout       = dout_q;

endmodule

// File: tb/tb_sm4_crypt_core.sv
// Scoreboard bench for sm4_crypt_core against the standard SM4 test vector.
module tb_sm4_crypt_core;
    import sm4_pkg::*;

    localparam logic [127:0] Key = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] Pt  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] Ct  = 128'h681edf34d206965e86b3e94f536e4246;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_loaded = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [4:0]   ikey_cnt;
    logic [31:0]  ikey = '0;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         busy;
    logic         prev_valid = 1'b0;
    logic [31:0]  rk [32];

    sm4_crypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_loaded (key_loaded),
        .decrypt    (decrypt),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ikey_cnt   (ikey_cnt),
        .ikey       (ikey),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        ikey <= rk[ikey_cnt];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: compare each new result against the scoreboard head.
    always @(negedge clk) begin
        if (dout_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_dout_valid", 128'(dout_valid), 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("dout", dout, mon_e.data);
                check("latency_cycle", 128'(cyc), 128'(mon_e.due));
            end
        end
        prev_valid = dout_valid;
    end

    function automatic logic [31:0] rol(input logic [31:0] b, input int n);
        return (b << n) | (b >> (32 - n));
    endfunction

    // Called at a negedge; returns at the negedge of the PREF cycle.
    task automatic send(input logic [127:0] blk, input logic dec, input logic [127:0] exp_blk,
                        input bit expect_out, output int waited);
        exp_t e;
        waited    = 0;
        din       = blk;
        decrypt   = dec;
        din_valid = 1'b1;
        while (!din_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("din_accepted", 128'(din_ready), 128'd1);
        if (expect_out) begin
            e.data = exp_blk;
            e.due  = cyc + 34;
            sb_q.push_back(e);
        end
        @(negedge clk);
        din_valid = 1'b0;
        decrypt   = ~dec;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(dout_valid), 128'd1);
    endtask

    initial begin
        logic [31:0] k [36];
        logic [31:0] ck, t, s;
        int w;

        k[0] = Key[127:96] ^ Fk0;
        k[1] = Key[95:64] ^ Fk1;
        k[2] = Key[63:32] ^ Fk2;
        k[3] = Key[31:0] ^ Fk3;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
            for (int j = 0; j < 4; j++) s[8*j +: 8] = sm4_sbox(t[8*j +: 8]);
            k[i+4] = k[i] ^ s ^ rol(s, 13) ^ rol(s, 23);
            rk[i]  = k[i+4];
        end

        // Reset with an unloaded key and a pending request.
        din_valid = 1'b1;
        din       = Pt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dout_valid", 128'(dout_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ikey_cnt", 128'(ikey_cnt), 128'd0);
        check("rst_dout", dout, 128'd0);
        repeat (5) begin
            check("gated_din_ready", 128'(din_ready), 128'd0);
            @(negedge clk);
        end
        check("gated_busy", 128'(busy), 128'd0);
        din_valid  = 1'b0;
        key_loaded = 1'b1;
        @(negedge clk);
        check("loaded_din_ready", 128'(din_ready), 128'd1);

        // Encrypt.
        send(Pt, 1'b0, Ct, 1'b1, w);
        check("enc_pref_ikey_cnt", 128'(ikey_cnt), 128'd0);
        wait_valid("enc_valid");
        @(negedge clk);

        // Decrypt with round-key address sequence 31..0.
        send(Ct, 1'b1, Pt, 1'b1, w);
        for (int i = 0; i < 32; i++) begin
            check("dec_ikey_cnt", 128'(ikey_cnt), 128'(31 - i));
            @(negedge clk);
        end
        wait_valid("dec_valid");
        @(negedge clk);

        // Backpressure, then back-to-back second block.
        dout_ready = 1'b0;
        send(Pt, 1'b0, Ct, 1'b1, w);
        wait_valid("bp_valid");
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", 128'(dout_valid), 128'd1);
            check("hold_dout", dout, Ct);
        end
        dout_ready = 1'b1;
        send(Ct, 1'b1, Pt, 1'b1, w);
        check("b2b_accept_wait", 128'(w), 128'd1);
        wait_valid("b2b_valid");
        @(negedge clk);

        // Key drop at round 10 (cycle 12 after acceptance).
        send(Pt, 1'b0, Ct, 1'b0, w);
        repeat (11) @(negedge clk);
        key_loaded = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_dout_valid", 128'(dout_valid), 128'd0);
        check("abort_ikey_cnt", 128'(ikey_cnt), 128'd0);
        repeat (40) @(negedge clk);
        key_loaded = 1'b1;
        @(negedge clk);

        // Reset at round 20 (cycle 22 after acceptance).
        send(Pt, 1'b0, Ct, 1'b0, w);
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", 128'(busy), 128'd0);
        check("mrst_dout_valid", 128'(dout_valid), 128'd0);
        check("mrst_ikey_cnt", 128'(ikey_cnt), 128'd0);
        check("mrst_dout", dout, 128'd0);
        send(Pt, 1'b0, Ct, 1'b1, w);
        wait_valid("post_rst_valid");
        @(negedge clk);
        @(negedge clk);

        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, expected end", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sm4_crypt_core.md
# sm4_crypt_core

Iterative SM4 data-path engine directly downstream of the SM4 key expansion block. It accepts one 128-bit block per transaction and runs the 32 SM4 rounds at one round per clock. Round keys are fetched from the key-expansion round-key RAM through the `ikey_cnt`/`ikey` read port, in forward order for encryption and reverse order for decryption. The result is returned on a valid/ready output handshake to the envelope controller.

## Interface
- No parameters; SM4 widths are fixed: block 128 bits, word and round key 32 bits, 32 rounds.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `key_loaded`  in  1  level; high while the round-key RAM holds a complete schedule. The integrator sets it on the key-expansion done pulse and clears it when key expansion is restarted.
- `decrypt`  in  1  mode; sampled together with `din` on acceptance. 0 = encrypt, 1 = decrypt.
- `din`  in  128  input block; word X0 is in bits [127:96].
- `din_valid`  in  1  input valid.
- `din_ready`  out  1  input ready; equals (state==IDLE) && key_loaded.
- `ikey_cnt`  out  5  round-key RAM read address.
- `ikey`  in  32  round-key RAM read data; valid one cycle after its address.
- `dout`  out  128  result block, Y0 in bits [127:96].
- `dout_valid`  out  1  result valid.
- `dout_ready`  in  1  result accepted by the consumer.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, PREF, RUN, DONE.
- IDLE → PREF when `din_valid` && `din_ready`. On this transition the block latches `din` into X[0:3], latches `decrypt`, and clears the round counter r.
- PREF (1 cycle): drives `ikey_cnt` with the first key index (0 for encrypt, 31 for decrypt), then moves to RUN.
- RUN (32 cycles, r = 0..31):
  - Computes X' = X0 ^ T(X1^X2^X3^`ikey`) and shifts the register to {X1,X2,X3,X'}.
  - Drives `ikey_cnt` with the index for round r+1 (r+1 for encrypt, 30−r for decrypt).
  - After r = 31: latches `dout` = {X3,X2,X1,X0} (the reverse transform R) and moves to DONE.
- T(B) = L(τ(B)):
  - τ applies the SM4 S-box to each byte.
  - L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24).
  - All arithmetic is 32-bit XOR and rotate; no carries.
- DONE: `dout_valid` = 1, `dout` held stable. DONE → IDLE when `dout_ready` = 1.
- `ikey_cnt` = 0 in IDLE and DONE.
- In RUN, the index presented after round 31 is a don't-care; the implementation drives it to 0 with no wrap.
- `key_loaded` falling while in PREF or RUN: abort to IDLE next cycle. No `dout_valid` is produced and the block is discarded.
- `key_loaded` falling in DONE has no effect; the result is already complete.
- `din_valid` while not IDLE is ignored (`din_ready` = 0). `decrypt` changes mid-run have no effect.

## Timing
- Reset values (sync, `rst_n` = 0 at a clock edge):
  - state = IDLE.
  - `dout_valid` = 0, `busy` = 0.
  - `dout` = 0, X = 0, r = 0, `ikey_cnt` = 0.
  - `din_ready` follows `key_loaded` from the first cycle after reset.
- A reset in any state, mid-run included, returns the block to IDLE with no output.
- Cycle map, with acceptance at the edge ending cycle 0:
  - Cycle 1: PREF, `ikey_cnt` = k0.
  - Cycles 2..33: RUN rounds 0..31, each using `ikey` addressed in the previous cycle.
  - Cycle 34: first cycle with `dout_valid` = 1.
- Latency: 34 cycles from acceptance to `dout_valid`.
- Back-to-back throughput: if `dout_ready` is high in cycle 34, the block is IDLE in cycle 35 and can accept the next block. One block therefore occupies 35 cycles.
- The RAM read port is driven only in PREF and RUN.
- The block must never be in PREF/RUN while the key expansion is writing the RAM. `key_loaded` = 0 during expansion guarantees this.

## Structure
- Shared package `sm4_pkg`, also used by the key expansion:
  - Function `sm4_sbox` (256-entry byte table).
  - Function `sm4_l` (data-path linear transform).
  - Constants FK0..FK3 and round count 32.
  - State encoding for this block.
- One combinational sub-module, `sm4_round`: inputs X0..X3 and rk; output X'. It instantiates four S-box lookups and L.
- The FSM, counter, and data registers live in `sm4_crypt_core`.

## Test plan
- Encrypt: key 0123456789abcdeffedcba9876543210 expanded, `din` = 0123456789abcdeffedcba9876543210 → `dout` = 681edf34d206965e86b3e94f536e4246 at exactly cycle 34.
- Decrypt: same key, `din` = 681edf34d206965e86b3e94f536e4246, `decrypt` = 1 → `dout` = 0123456789abcdeffedcba9876543210. Monitor checks the `ikey_cnt` sequence 31,30,…,0.
- Backpressure and back-to-back:
  - Hold `dout_ready` = 0 for 10 cycles in DONE → `dout_valid` and `dout` stay constant.
  - Release `dout_ready` → IDLE. A second block is accepted one cycle later and produces its correct result at its own cycle 34.
- Key gating:
  - `key_loaded` = 0 with `din_valid` = 1 → `din_ready` = 0 and no acceptance.
  - Drop `key_loaded` at RUN round 10 → IDLE next cycle and no `dout_valid`.
- Reset mid-run: `rst_n` = 0 for one cycle at round 20 → next cycle state = IDLE, `dout_valid` = 0, `busy` = 0, `ikey_cnt` = 0. A fresh encrypt then yields 681edf34d206965e86b3e94f536e4246.
